// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - SAP-1 control-word bit indices, opcodes and ring-state constants
package sap1_pkg;

  localparam int T_STATES = 6;

  // Control word bit positions, MSB (Cp) down to LSB (Lo)
  localparam int CP = 11;
  localparam int EP = 10;
  localparam int LM = 9;
  localparam int CE = 8;
  localparam int LI = 7;
  localparam int EI = 6;
  localparam int LA = 5;
  localparam int EA = 4;
  localparam int SU = 3;
  localparam int EU = 2;
  localparam int LB = 1;
  localparam int LO = 0;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [T_STATES-1:0] T1 = 6'b000001;
  localparam logic [T_STATES-1:0] T2 = 6'b000010;
  localparam logic [T_STATES-1:0] T3 = 6'b000100;
  localparam logic [T_STATES-1:0] T4 = 6'b001000;
  localparam logic [T_STATES-1:0] T5 = 6'b010000;
  localparam logic [T_STATES-1:0] T6 = 6'b100000;

  function automatic logic is_onehot(input logic [T_STATES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - one-hot T-state ring with hold and self-correction to T1
module ring_counter
  import sap1_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  output logic [T_STATES-1:0] t_state
);

  // Corruption recovery takes priority over hold so a halted machine cannot freeze on a bad value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_state <= T1;
    end else if (!is_onehot(t_state)) begin
      t_state <= T1;
    end else if (!hold) begin
      t_state <= {t_state[T_STATES-2:0], t_state[T_STATES-1]};
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - SAP-1 ring counter plus microcode decode and halt detection
module control_sequencer
  import sap1_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          opcode,
  output logic [11:0]         con,
  output logic [T_STATES-1:0] t_state,
  output logic                halt
);

  logic        halted;
  logic        hlt_now;
  logic [11:0] word;

  // HLT is seen combinationally in T4 so the ring holds on the very edge that sets halted.
  assign hlt_now = (t_state == T4) && (opcode == OP_HLT);
  assign halt    = halted | hlt_now;

  ring_counter u_ring (
    .clk     (clk),
    .rst     (rst),
    .hold    (halt),
    .t_state (t_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (hlt_now) begin
      halted <= 1'b1;
    end
  end

  always_comb begin
    word = '0;
    case (t_state)
      T1: begin word[EP] = 1'b1; word[LM] = 1'b1; end
      T2: word[CP] = 1'b1;
      T3: begin word[CE] = 1'b1; word[LI] = 1'b1; end
      T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin word[LM] = 1'b1; word[EI] = 1'b1; end
          OP_OUT:                 begin word[EA] = 1'b1; word[LO] = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (opcode)
          OP_LDA:         begin word[CE] = 1'b1; word[LA] = 1'b1; end
          OP_ADD, OP_SUB: begin word[CE] = 1'b1; word[LB] = 1'b1; end
          default: ;
        endcase
      end
      T6: begin
        case (opcode)
          OP_ADD: begin word[LA] = 1'b1; word[EU] = 1'b1; end
          OP_SUB: begin word[LA] = 1'b1; word[SU] = 1'b1; word[EU] = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign con = halt ? 12'h000 : word;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed and randomized checks of control_sequencer against a step-index model
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opcode = 4'h0;
  logic [11:0] con;
  logic [5:0]  t_state;
  logic        halt;

  int errors = 0;
  int checks = 0;
  int m_step = 0;
  bit m_halted = 1'b0;

  control_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .con     (con),
    .t_state (t_state),
    .halt    (halt)
  );

  always #5 clk = ~clk;

  // Control word by instruction step (0 = T1 .. 5 = T6), straight from the microcode table.
  function automatic logic [11:0] ref_con(input int step, input logic [3:0] op);
    logic [11:0] fetch [3];
    logic [11:0] row [3];
    fetch = '{12'h600, 12'h800, 12'h180};
    if (step < 3) return fetch[step];
    case (op)
      4'h0:    row = '{12'h240, 12'h120, 12'h000};
      4'h1:    row = '{12'h240, 12'h102, 12'h024};
      4'h2:    row = '{12'h240, 12'h102, 12'h02C};
      4'hE:    row = '{12'h011, 12'h000, 12'h000};
      default: row = '{12'h000, 12'h000, 12'h000};
    endcase
    return row[step-3];
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (step %0d op %h)", tag, obs, exp, m_step, opcode);
    end
  endtask

  task automatic check_all(input string tag);
    logic        e_halt;
    logic [11:0] e_con;
    logic [5:0]  e_state;
    e_halt  = m_halted || (m_step == 3 && opcode == 4'hF);
    e_con   = e_halt ? 12'h000 : ref_con(m_step, opcode);
    e_state = 6'b000001 << m_step;
    chk({tag, " t_state"}, {6'b0, t_state}, {6'b0, e_state});
    chk({tag, " halt"}, {11'b0, halt}, {11'b0, e_halt});
    chk({tag, " con"}, con, e_con);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) begin
      m_step = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_step == 3 && opcode == 4'hF) m_halted = 1'b1;
      else m_step = (m_step + 1) % 6;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  // Async reset between edges: outputs must change before any clock edge.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    m_step = 0;
    m_halted = 1'b0;
    #1 check_all(tag);
    tick({tag, " held"});
    rst = 1'b0;
  endtask

  // Starts in T1; fetch runs with a junk opcode, the real one appears after the IR load edge.
  task automatic run_instr(input logic [3:0] op, input string tag);
    opcode = 4'($urandom);
    tick({tag, " T2"});
    tick({tag, " T3"});
    opcode = op;
    tick({tag, " T4"});
    tick({tag, " T5"});
    tick({tag, " T6"});
    tick({tag, " T1"});
  endtask

  initial begin
    tick("reset");
    rst = 1'b0;

    run_instr(4'h0, "lda");
    run_instr(4'h2, "sub");
    run_instr(4'h1, "add");
    run_instr(4'hE, "out");
    run_instr(4'h5, "nop");

    for (int i = 0; i < 15; i++) begin
      run_instr(4'($urandom_range(0, 14)), "rand");
    end

    opcode = 4'hF;
    tick("hlt T2");
    tick("hlt T3");
    tick("hlt T4");
    for (int i = 0; i < 20; i++) tick("halted");
    opcode = 4'h0;
    #1 check_all("halted op change");
    tick("halted lda");
    tick("halted lda2");
    pulse_reset("rst halted");

    run_instr(4'h0, "post halt lda");

    opcode = 4'h1;
    tick("add T2");
    tick("add T3");
    tick("add T4");
    tick("add T5");
    pulse_reset("rst mid add");

    run_instr(4'h1, "restart add");
    for (int i = 0; i < 5; i++) begin
      run_instr(4'($urandom_range(0, 14)), "rand2");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
